shift_rotate_seq: RTL and testbench
===================================

# shift_rotate_seq

Multi-cycle sequencer for the CPU's shift/rotate path. It accepts one shift or rotate request through a start/done handshake and applies the amount in chunks of at most STEP bits per cycle through a narrow combinational step unit, so no full 32-way barrel rotator is needed. It sits beside the ALU and is started by the control unit for SHR, SHRA, SHL, ROR and ROL instructions. The control unit stalls on `busy`.

## Interface
- `STEP`, default 8: maximum bits moved per BUSY cycle; must be a power of two, 1..16.
- `clk` input 1: the single clock; all state updates on the rising edge.
- `reset` input 1: synchronous, active-high; sampled on the `clk` rising edge.
- `start` input 1: request strobe; accepted only in IDLE.
- `op` input 3: 000 SHR (logical right), 001 SHRA (arithmetic right), 010 SHL, 011 ROR, 100 ROL; 101–111 are illegal.
- `in_data` input 32: operand; sampled with `start`.
- `amount` input 5: shift count 0..31; sampled with `start`.
- `busy` output 1: high in BUSY and DONE.
- `done` output 1: single-cycle pulse; `result` is valid while it is high.
- `result` output 32: working/result register.

## Operation
- States:
  - IDLE: `start` moves to BUSY.
  - BUSY: moves to DONE when `rem` = 0.
  - DONE: always returns to IDLE after one cycle.
- Load, on the edge that samples `start` in IDLE:
  - `result` ← `in_data`; latch `op`.
  - `rem` ← `amount`, except ROL: `rem` ← (32 − `amount`) mod 32, executed as ROR.
  - Illegal `op`: `rem` ← 0, so `result` = `in_data`.
- BUSY step, on each edge with `rem` ≠ 0:
  - k = min(`rem`, STEP); `rem` ← `rem` − k.
  - SHR: `result` ← `result` >> k with zero fill.
  - SHRA: `result` ← `result` >> k with `result[31]` fill.
  - SHL: `result` ← `result` << k with zero fill.
  - ROR/ROL: `result` ← {`result[k-1:0]`, `result[31:k]`}.
- `rem` is 5-bit unsigned and never underflows because k ≤ `rem`.
- `start` in BUSY or DONE is ignored and not queued. `op`, `in_data` and `amount` are don't-care outside the load edge.
- Once `done` pulses, `result` holds until the next accepted `start` reloads it.
- Reset, including mid-operation: next state IDLE, `busy` = 0, `done` = 0, `result` = 0, `rem` = 0. Work in progress is discarded.

## Timing
- `start` is high in cycle 0. BUSY covers cycles 1 .. 1+N, where N = ceil(`rem`/STEP). DONE, and therefore `done`, is at cycle 2+N.
- Latency examples with STEP = 8:
  - amount 0: `done` at cycle 2.
  - amount 8: `done` at cycle 3.
  - amount 31: `done` at cycle 6.
  - ROL 1 (runs as ROR 31): `done` at cycle 6.
- `busy` rises in cycle 1 and falls in the cycle after `done`. The earliest next accepted `start` is the cycle after DONE.
- All outputs are registered; there is no combinational path from inputs to outputs.

## Structure
- Shared package `shift_pkg` holds:
  - Op-code constants: `OP_SHR`, `OP_SHRA`, `OP_SHL`, `OP_ROR`, `OP_ROL`.
  - State encoding: `S_IDLE`, `S_BUSY`, `S_DONE`.
  - `DATA_W` = 32.
- Sub-module `shift_step`: combinational; inputs `data[31:0]`, `op`, `k[4:0]` (k ≤ STEP); output is the stepped word. The top level contains only the FSM, `rem`, the `result` register and the ROL conversion.

## Test plan
All scenarios use STEP = 8.
- SHR: `in_data` 0x80000000, amount 4 -> `result` 0x08000000, `done` at cycle 3, `busy` high in cycles 1–3.
- SHRA: 0x80000000, amount 31 -> 0xFFFFFFFF, `done` at cycle 6. SHL: 0x00000001, amount 31 -> 0x80000000.
- ROR: 0x12345678, amount 8 -> 0x78123456. ROL: 0x80000001, amount 1 -> 0x00000003, `done` at cycle 6.
- Amount 0, and illegal op 111 with amount 20 -> `result` = `in_data` (0xDEADBEEF), `done` at cycle 2.
- `start` with different operands pulsed in cycles 1–4 of a running ROR 0x12345678 by 16 -> ignored; `result` 0x56781234.
- Reset asserted in cycle 3 of a 31-bit op -> IDLE next cycle, `busy` = 0, `done` = 0, `result` = 0. A fresh SHR of 0xF0 by 4 then gives 0x0F with normal latency.

Source files
------------

// File: rtl/shift_rotate_seq_pkg.sv
// Shared definitions for the multi-cycle shift/rotate sequencer:
// operand width, op-code values and FSM state encoding.
package shift_pkg;

    localparam int DATA_W = 32;

    localparam logic [2:0] OP_SHR  = 3'b000;
    localparam logic [2:0] OP_SHRA = 3'b001;
    localparam logic [2:0] OP_SHL  = 3'b010;
    localparam logic [2:0] OP_ROR  = 3'b011;
    localparam logic [2:0] OP_ROL  = 3'b100;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_BUSY = 2'd1,
        S_DONE = 2'd2
    } state_e;

endpackage

// File: rtl/shift_rotate_seq_step.sv
// Narrow combinational step unit: moves the word by k bits, 0 <= k <= STEP.
// Only STEP+1 fixed shift positions exist, so no full barrel rotator is built.
module shift_step
    import shift_pkg::*;
#(
    parameter int STEP = 8
) (
    input  logic [DATA_W-1:0] data,
    input  logic [2:0]        op,
    input  logic [4:0]        k,
    output logic [DATA_W-1:0] stepped
);

    always_comb begin
        stepped = data;
        for (int j = 1; j <= STEP; j++) begin
            if (k == 5'(j)) begin
                case (op)
                    OP_SHR:  stepped = data >> j;
                    OP_SHRA: stepped = DATA_W'($signed(data) >>> j);
                    OP_SHL:  stepped = data << j;
                    // ROL is converted to ROR at load time, so both land here
                    OP_ROR,
                    OP_ROL:  stepped = (data >> j) | (data << (DATA_W - j));
                    default: stepped = data;
                endcase
            end
        end
    end

endmodule

// File: rtl/shift_rotate_seq.sv
// Shift/rotate sequencer: loads an operand on start, then applies the amount
// in chunks of at most STEP bits per cycle, pulsing done when finished.
module shift_rotate_seq
    import shift_pkg::*;
#(
    parameter int STEP = 8
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    input  logic [2:0]        op,
    input  logic [DATA_W-1:0] in_data,
    input  logic [4:0]        amount,
    output logic              busy,
    output logic              done,
    output logic [DATA_W-1:0] result
);

    state_e            state_q, state_d;
    logic [4:0]        rem_q, rem_d;
    logic [2:0]        op_q, op_d;
    logic [DATA_W-1:0] result_q, result_d;
    logic [4:0]        k;
    logic [DATA_W-1:0] stepped;

    shift_step #(.STEP(STEP)) u_step (
        .data    (result_q),
        .op      (op_q),
        .k       (k),
        .stepped (stepped)
    );

    always_comb begin
        state_d  = state_q;
        rem_d    = rem_q;
        op_d     = op_q;
        result_d = result_q;
        k        = (rem_q < 5'(STEP)) ? rem_q : 5'(STEP);

        case (state_q)
            S_IDLE: begin
                if (start) begin
                    state_d  = S_BUSY;
                    result_d = in_data;
                    op_d     = op;
                    rem_d    = amount;
                    // Rotate left by n equals rotate right by (32 - n) mod 32
                    if (op == OP_ROL) begin
                        op_d  = OP_ROR;
                        rem_d = 5'd0 - amount;
                    end else if (op > OP_ROL) begin
                        rem_d = '0;
                    end
                end
            end
            S_BUSY: begin
                if (rem_q == 5'd0) begin
                    state_d = S_DONE;
                end else begin
                    rem_d    = rem_q - k;
                    result_d = stepped;
                end
            end
            S_DONE:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q  <= S_IDLE;
            rem_q    <= '0;
            op_q     <= '0;
            result_q <= '0;
        end else begin
            state_q  <= state_d;
            rem_q    <= rem_d;
            op_q     <= op_d;
            result_q <= result_d;
        end
    end

    assign busy   = (state_q != S_IDLE);
    assign done   = (state_q == S_DONE);
    assign result = result_q;

endmodule

// File: tb/tb_shift_rotate_seq.sv
// Directed self-checking bench for shift_rotate_seq with STEP = 8.
module tb_shift_rotate_seq;

    logic        clk;
    logic        reset;
    logic        start;
    logic [2:0]  op;
    logic [31:0] in_data;
    logic [4:0]  amount;
    logic        busy;
    logic        done;
    logic [31:0] result;

    int errors = 0;
    int checks = 0;

    shift_rotate_seq #(.STEP(8)) dut (
        .clk     (clk),
        .reset   (reset),
        .start   (start),
        .op      (op),
        .in_data (in_data),
        .amount  (amount),
        .busy    (busy),
        .done    (done),
        .result  (result)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Moves to the next cycle, pulses start there (cycle 0) and waits for done.
    // Returns the cycle done appeared in (40 on timeout), result then, busy in cycle 1.
    task automatic launch(input logic [2:0] o, input logic [31:0] d, input logic [4:0] a,
                          output int cyc, output logic [31:0] res, output logic busy1);
        @(posedge clk); #1;
        start = 1'b1; op = o; in_data = d; amount = a;
        @(posedge clk); #1;
        start = 1'b0; op = 3'b000; in_data = 32'h0; amount = 5'd0;
        busy1 = busy;
        cyc = 1;
        while (!done && cyc < 40) begin
            @(posedge clk); #1;
            cyc++;
        end
        res = result;
    endtask

    task automatic test_reset();
        reset = 1'b1; start = 1'b0; op = 3'b000; in_data = 32'h0; amount = 5'd0;
        repeat (2) @(posedge clk);
        #1;
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy: got %b want 0", busy); end
        checks++; if (done !== 1'b0) begin errors++; $display("FAIL reset_done: got %b want 0", done); end
        checks++; if (result !== 32'h0) begin errors++; $display("FAIL reset_result: got %h want 00000000", result); end
        reset = 1'b0;
    endtask

    task automatic test_shr();
        int cyc; logic [31:0] res; logic b1;
        launch(3'b000, 32'h8000_0000, 5'd4, cyc, res, b1);
        checks++; if (res !== 32'h0800_0000) begin errors++; $display("FAIL shr_result: got %h want 08000000", res); end
        checks++; if (cyc != 3) begin errors++; $display("FAIL shr_latency: got %0d want 3", cyc); end
        checks++; if (b1 !== 1'b1) begin errors++; $display("FAIL shr_busy_c1: got %b want 1", b1); end
        checks++; if (busy !== 1'b1) begin errors++; $display("FAIL shr_busy_c3: got %b want 1", busy); end
        @(posedge clk); #1;
        checks++; if (busy !== 1'b0 || done !== 1'b0) begin errors++; $display("FAIL shr_after: busy=%b done=%b want 0 0", busy, done); end
        checks++; if (result !== 32'h0800_0000) begin errors++; $display("FAIL shr_hold: got %h want 08000000", result); end
    endtask

    task automatic test_shra_shl();
        int cyc; logic [31:0] res; logic b1;
        launch(3'b001, 32'h8000_0000, 5'd31, cyc, res, b1);
        checks++; if (res !== 32'hFFFF_FFFF) begin errors++; $display("FAIL shra_result: got %h want ffffffff", res); end
        checks++; if (cyc != 6) begin errors++; $display("FAIL shra_latency: got %0d want 6", cyc); end
        launch(3'b010, 32'h0000_0001, 5'd31, cyc, res, b1);
        checks++; if (res !== 32'h8000_0000) begin errors++; $display("FAIL shl_result: got %h want 80000000", res); end
        checks++; if (cyc != 6) begin errors++; $display("FAIL shl_latency: got %0d want 6", cyc); end
        launch(3'b000, 32'hF000_0000, 5'd12, cyc, res, b1);
        checks++; if (res !== 32'h000F_0000) begin errors++; $display("FAIL shr12_result: got %h want 000f0000", res); end
        checks++; if (cyc != 4) begin errors++; $display("FAIL shr12_latency: got %0d want 4", cyc); end
    endtask

    task automatic test_rotate();
        int cyc; logic [31:0] res; logic b1;
        launch(3'b011, 32'h1234_5678, 5'd8, cyc, res, b1);
        checks++; if (res !== 32'h7812_3456) begin errors++; $display("FAIL ror_result: got %h want 78123456", res); end
        checks++; if (cyc != 3) begin errors++; $display("FAIL ror_latency: got %0d want 3", cyc); end
        launch(3'b100, 32'h8000_0001, 5'd1, cyc, res, b1);
        checks++; if (res !== 32'h0000_0003) begin errors++; $display("FAIL rol_result: got %h want 00000003", res); end
        checks++; if (cyc != 6) begin errors++; $display("FAIL rol_latency: got %0d want 6", cyc); end
        launch(3'b011, 32'h1234_5678, 5'd4, cyc, res, b1);
        checks++; if (res !== 32'h8123_4567) begin errors++; $display("FAIL ror4_result: got %h want 81234567", res); end
    endtask

    task automatic test_zero_illegal();
        int cyc; logic [31:0] res; logic b1;
        launch(3'b010, 32'hDEAD_BEEF, 5'd0, cyc, res, b1);
        checks++; if (res !== 32'hDEAD_BEEF) begin errors++; $display("FAIL amt0_result: got %h want deadbeef", res); end
        checks++; if (cyc != 2) begin errors++; $display("FAIL amt0_latency: got %0d want 2", cyc); end
        launch(3'b111, 32'hDEAD_BEEF, 5'd20, cyc, res, b1);
        checks++; if (res !== 32'hDEAD_BEEF) begin errors++; $display("FAIL illegal_result: got %h want deadbeef", res); end
        checks++; if (cyc != 2) begin errors++; $display("FAIL illegal_latency: got %0d want 2", cyc); end
    endtask

    task automatic test_ignored_start();
        @(posedge clk); #1;
        start = 1'b1; op = 3'b011; in_data = 32'h1234_5678; amount = 5'd16;
        for (int c = 1; c <= 4; c++) begin
            @(posedge clk); #1;
            start = 1'b1; op = 3'(c % 3); in_data = 32'hFFFF_0000 ^ 32'(c); amount = 5'(c + 2);
            if (c == 4) begin
                checks++; if (done !== 1'b1) begin errors++; $display("FAIL ign_done_c4: got %b want 1", done); end
            end
        end
        @(posedge clk); #1;
        start = 1'b0;
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL ign_busy_c5: got %b want 0", busy); end
        checks++; if (result !== 32'h5678_1234) begin errors++; $display("FAIL ign_result: got %h want 56781234", result); end
    endtask

    task automatic test_reset_mid();
        int cyc; logic [31:0] res; logic b1;
        @(posedge clk); #1;
        start = 1'b1; op = 3'b000; in_data = 32'hFFFF_FFFF; amount = 5'd31;
        @(posedge clk); #1;
        start = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        reset = 1'b1;
        @(posedge clk); #1;
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL midrst_busy: got %b want 0", busy); end
        checks++; if (done !== 1'b0) begin errors++; $display("FAIL midrst_done: got %b want 0", done); end
        checks++; if (result !== 32'h0) begin errors++; $display("FAIL midrst_result: got %h want 00000000", result); end
        reset = 1'b0;
        launch(3'b000, 32'h0000_00F0, 5'd4, cyc, res, b1);
        checks++; if (res !== 32'h0000_000F) begin errors++; $display("FAIL postrst_result: got %h want 0000000f", res); end
        checks++; if (cyc != 3) begin errors++; $display("FAIL postrst_latency: got %0d want 3", cyc); end
    endtask

    initial begin
        test_reset();
        test_shr();
        test_shra_shl();
        test_rotate();
        test_zero_illegal();
        test_ignored_start();
        test_reset_mid();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
